// File: rtl/instr_dispatch.sv
// In-order instruction dispatcher: buffers tagged words in a small FIFO and
// presents the head entry to its target core, retiring on that core's ready.
module instr_dispatch #(
    parameter int N     = 3,
    parameter int DEPTH = 4,
    localparam int CORE_SEL_W = (N <= 1) ? 1 : $clog2(N),
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  instr_valid,
    input  logic [31:0]           instr_word,
    input  logic [CORE_SEL_W-1:0] instr_core_sel,
    output logic                  instr_ready,
    output logic [N-1:0]          core_instr_valid,
    output logic [31:0]           core_instr_word,
    input  logic [N-1:0]          core_ready_vec,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [15:0]           issued_count,
    output logic                  bad_sel_err
);

    localparam logic [CORE_SEL_W:0] SEL_LIMIT = (CORE_SEL_W + 1)'(N);

    logic [31:0]           word_mem [DEPTH];
    logic [CORE_SEL_W-1:0] sel_mem  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  empty;
    logic                  sel_legal;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  head_ready;
    logic [CORE_SEL_W-1:0] head_sel;
    logic [31:0]           head_word;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. instr_ready depends only on registered occupancy; a core
    // transfer is core_instr_valid[i] && core_ready_vec[i] for the head's core.
    assign instr_ready = resetN && (fifo_count < CNT_W'(DEPTH));
    assign empty       = (fifo_count == '0);
    assign sel_legal   = ({1'b0, instr_core_sel} < SEL_LIMIT);
    assign accept      = instr_valid && instr_ready;
    assign push        = accept && sel_legal;
    assign pop         = !empty && head_ready;
    assign head_sel    = sel_mem[rd_ptr];
    assign head_word   = word_mem[rd_ptr];

    // Decode the head's select without indexing past N for out-of-range codes.
    always_comb begin
        core_instr_valid = '0;
        head_ready       = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (head_sel == CORE_SEL_W'(i)) begin
                core_instr_valid[i] = !empty;
                head_ready          = core_ready_vec[i];
            end
        end
        core_instr_word = empty ? 32'h0 : head_word;
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= instr_word;
            sel_mem[wr_ptr]  <= instr_core_sel;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            issued_count <= '0;
            bad_sel_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                issued_count <= issued_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (accept && !sel_legal) begin
                bad_sel_err <= 1'b1;
            end
        end
    end

endmodule
